// File: rtl/lfsr_sequence_checker_if.sv
// Received random-word stream: one 32-bit generator word plus its valid strobe.
// The master modport drives the stream and the slave modport (the checker) samples it.
interface lfsr_sequence_checker_if;
  logic [31:0] data_i;
  logic        data_v;

  modport master (output data_i, output data_v);
  modport slave  (input  data_i, input  data_v);
endinterface

// File: rtl/lfsr_sequence_checker.sv
// Self-synchronising checker for the 32-bit one-bit-per-step generator sequence.
// It seeds from the stream, verifies a run of predictions, then flywheels and counts mispredictions.
module lfsr_sequence_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  lfsr_sequence_checker_if.slave      in_if,
  input  logic                        clr_i,
  output logic                        locked_o,
  output logic                        err_o,
  output logic [CNT_W-1:0]            err_cnt_o,
  output logic [1:0]                  state_o
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int MISS_W = $clog2(LOSS_COUNT + 1);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         ref_q, ref_d;
  logic [RUN_W-1:0]    run_cnt_q, run_cnt_d;
  logic [MISS_W-1:0]   miss_cnt_q, miss_cnt_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  function automatic logic [31:0] step(input logic [31:0] x);
    return {x[31] ^ x[30] ^ x[29] ^ x[27] ^ x[25] ^ x[0], x[31:1]};
  endfunction

  always_comb begin
    state_d    = state_q;
    ref_d      = ref_q;
    run_cnt_d  = run_cnt_q;
    miss_cnt_d = miss_cnt_q;
    err_d      = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (in_if.data_v) begin
      case (state_q)
        HUNT: begin
          // All-zero is the generator's lock-up word, so it can never seed.
          if (in_if.data_i != 32'd0) begin
            ref_d     = step(in_if.data_i);
            run_cnt_d = '0;
            state_d   = VERIFY;
          end
        end

        VERIFY: begin
          if (in_if.data_i == ref_q) begin
            ref_d     = step(in_if.data_i);
            run_cnt_d = run_cnt_q + RUN_W'(1);
            if (int'(run_cnt_q) + 1 == LOCK_COUNT) begin
              state_d    = LOCKED;
              miss_cnt_d = '0;
            end
          end else if (in_if.data_i != 32'd0) begin
            ref_d     = step(in_if.data_i);
            run_cnt_d = '0;
          end else begin
            state_d = HUNT;
          end
        end

        LOCKED: begin
          // Flywheel on our own prediction so corrupted words cannot pull us off sequence.
          ref_d = step(ref_q);
          if (in_if.data_i == ref_q) begin
            miss_cnt_d = '0;
          end else begin
            err_d      = 1'b1;
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
            if (err_cnt_q != {CNT_W{1'b1}}) begin
              err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            if (int'(miss_cnt_q) + 1 == LOSS_COUNT) begin
              state_d = HUNT;
            end
          end
        end

        default: state_d = HUNT;
      endcase
    end

    if (clr_i) begin
      err_cnt_d = '0;
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= HUNT;
      ref_q      <= 32'd0;
      run_cnt_q  <= '0;
      miss_cnt_q <= '0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ref_q      <= ref_d;
      run_cnt_q  <= run_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign locked_o  = locked_q;
  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;
  assign state_o   = state_q;

endmodule

// File: doc/lfsr_sequence_checker.md
# lfsr_sequence_checker

Receive-side companion to the 32-bit random generator. Samples a stream of words produced by the generator's one-bit-per-step shift sequence, self-synchronises to it, then predicts every following word and counts mismatches. Placed at the consuming end of any random-word link (board-to-board game sync, SVGA pattern self-test) to prove that both ends run the same sequence.

## Interface
Parameters:
- LOCK_COUNT, 4: consecutive correct predictions needed to declare lock (≥1).
- LOSS_COUNT, 3: consecutive mispredictions while locked that drop lock (≥1).
- CNT_W, 16: width of the error counter.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- data_i  in  32  received generator word.
- data_v  in  1  data_i valid; each valid word is exactly one generator step after the previous valid word.
- clr_i  in  1  synchronous clear of err_cnt_o.
- locked_o  out  1  checker is locked to the sequence.
- err_o  out  1  one-cycle pulse per mispredicted word while locked.
- err_cnt_o  out  CNT_W  saturating count of mispredictions while locked.
- state_o  out  2  current state: 0 HUNT, 1 VERIFY, 2 LOCKED.

## Operation
- step(x) = {x[31]^x[30]^x[29]^x[27]^x[25]^x[0], x[31:1]}. Internal regs: ref (32-bit predicted word), run_cnt, miss_cnt.
- All-zero is the lock-up word of this sequence; never used as a seed.
- HUNT: on data_v with data_i≠0: ref←step(data_i), run_cnt←0, go VERIFY. data_i=0 ignored.
- VERIFY, on data_v:
  - data_i==ref: ref←step(data_i), run_cnt+1; if run_cnt+1==LOCK_COUNT go LOCKED, miss_cnt←0.
  - mismatch, data_i≠0: reseed ref←step(data_i), run_cnt←0, stay VERIFY.
  - mismatch, data_i=0: go HUNT.
  - No error counting in HUNT/VERIFY.
- LOCKED, on data_v (flywheel, never reseeds):
  - ref←step(ref) always.
  - match: miss_cnt←0.
  - mismatch: err_o pulse, err_cnt_o+1 saturating at 2^CNT_W−1, miss_cnt+1; if miss_cnt+1==LOSS_COUNT go HUNT.
- No data_v: all state and registers hold; err_o 0.
- clr_i: err_cnt_o←0; has priority over a same-cycle increment (that error not counted, err_o still pulses). No effect on state.
- locked_o = (state==LOCKED), registered.

## Timing
- Reset (rst=0 at an edge): state HUNT, ref 0, run_cnt 0, miss_cnt 0, locked_o 0, err_o 0, err_cnt_o 0, state_o 0. Applies mid-operation; any data_v in the same cycle is dropped.
- All outputs registered; one-cycle latency from the deciding data_v edge.
- Lock: first nonzero word seeds; locked_o rises the cycle after the LOCK_COUNT-th matching word (minimum LOCK_COUNT+1 valid words).
- err_o high exactly the cycle after a mismatched valid word; err_cnt_o updates on the same edge.
- Loss: locked_o falls the cycle after the LOSS_COUNT-th consecutive mismatch; that word is also counted and pulses err_o.
- Back-to-back data_v every cycle supported with no stall; gaps of any length allowed.

## Test plan
- Lock: after reset feed 0x00000001, 0x80000000, 0xC0000000, 0x60000000, 0x30000000 on consecutive cycles (LOCK_COUNT=4) -> locked_o 0 through 5th sample, 1 the cycle after; err_cnt_o 0; state_o 1 then 2.
- Single error: locked, expected 0x98000000, send 0x98000001, then continue correct sequence -> err_o single pulse, err_cnt_o=1, locked_o stays 1, next correct word produces no error.
- Loss: locked, send 3 consecutive wrong words (LOSS_COUNT=3) -> err_cnt_o=3, three err_o pulses, locked_o 0 after third, state_o 0; correct words thereafter re-lock after 5 valid words.
- Zero/gaps: in HUNT feed 0x00000000 ×3 -> stays HUNT; then seed sequence with data_v toggling 1/0 -> lock identical to scenario 1, only delayed.
- Saturation/clear: CNT_W=2, force 5 errors while locked with LOSS_COUNT=8 -> err_cnt_o stops at 3; assert clr_i on cycle of a 6th error -> err_cnt_o=0, err_o pulses.
- Reset mid-lock: rst=0 for one cycle while locked and data_v=1 -> next cycle locked_o 0, err_cnt_o 0, state_o 0; resumed stream re-locks normally.
